// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and defaults for the round-robin Gray-to-binary conversion arbiter.
package gray_conv_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage : gray_conv_arbiter_pkg

// File: rtl/gray_conv_arbiter_gray2bin.sv
// Combinational Gray-to-binary converter: running XOR from the MSB down.
module gray2bin_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_c
);

  logic acc;

  always_comb begin
    bin_c            = '0;
    acc              = gray[WIDTH-1];
    bin_c[WIDTH-1]   = acc;
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      acc      = acc ^ gray[i];
      bin_c[i] = acc;
    end
  end

endmodule : gray2bin_comb

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray-to-binary stage among NREQ requesters.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NREQ  = DEF_NREQ,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_bin,
  output logic [WIDTH-1:0]      out_gray,
  output logic [IDW-1:0]        out_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      conv_count
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   gray_q, gray_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   conv_count_q, conv_count_d;
  logic               out_valid_q;
  logic               busy_q;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     cand;
  logic [WIDTH-1:0]   grant_gray;
  logic [WIDTH-1:0]   conv_bin_c;

  gray2bin_comb #(.WIDTH(WIDTH)) u_gray2bin (
    .gray  (gray_q),
    .bin_c (conv_bin_c)
  );

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_gray  = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
        grant_gray  = req_gray[32'(cand)*WIDTH +: WIDTH];
      end
    end
  end

  // Only combinational output: depends on registered state and req_valid alone.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    gray_d       = gray_q;
    bin_d        = bin_q;
    conv_count_d = conv_count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          gray_d  = grant_gray;
          id_d    = grant_idx;
          ptr_d   = IDW'((32'(grant_idx) + 32'd1) % NREQ);
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        bin_d   = conv_bin_c;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          conv_count_d = conv_count_q + CNT_W'(1);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      gray_q       <= '0;
      bin_q        <= '0;
      conv_count_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      gray_q       <= gray_d;
      bin_q        <= bin_d;
      conv_count_q <= conv_count_d;
      out_valid_q  <= (state_d == ST_OUT);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_bin    = bin_q;
  assign out_gray   = gray_q;
  assign out_id     = id_q;
  assign conv_count = conv_count_q;

endmodule : gray_conv_arbiter

// File: tb/tb_gray_conv_arbiter.sv
// Randomized self-checking bench for gray_conv_arbiter against a transaction-level model.
module tb_gray_conv_arbiter;
  import gray_conv_arbiter_pkg::*;

  localparam int unsigned W   = DEF_WIDTH;
  localparam int unsigned N   = DEF_NREQ;
  localparam int unsigned IDW = $clog2(N);

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_gray;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_bin;
  logic [W-1:0]     out_gray;
  logic [IDW-1:0]   out_id;
  logic             busy;
  logic [15:0]      conv_count;

  gray_conv_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bin    (out_bin),
    .out_gray   (out_gray),
    .out_id     (out_id),
    .busy       (busy),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;

  // Transaction-level model: pending requests, rotation pointer, accepted count.
  bit          pend [N];
  logic [W-1:0] word [N];
  int          mptr;
  logic [15:0] exp_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Binary value of a Gray code is the XOR of all its right shifts.
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < int'(W); s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int pick();
    for (int i = 0; i < int'(N); i++) begin
      int j;
      j = (mptr + i) % int'(N);
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < int'(N); i++) begin
      req_valid[i]         = pend[i];
      req_gray[i*W +: W]   = word[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    clear_pend();
    drive_reqs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    exp_count = 16'h0000;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    out_ready = 1'b0;
    drive_reqs();
    #1 check("idle_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  // One full transaction: grant, convert, optional backpressure, handshake.
  task automatic run_txn(input int hold, output int k_o, output logic [W-1:0] bin_o);
    int k;
    logic [W-1:0] g;
    bin_o = '0;
    @(negedge clk);
    out_ready = 1'b0;
    drive_reqs();
    #1;
    k = pick();
    k_o = k;
    if (k < 0) begin
      check("grant_none", 32'(req_ready), 32'd0);
      return;
    end
    check("grant_onehot", 32'(req_ready), 32'd1 << k);
    g = word[k];
    @(posedge clk);
    pend[k] = 1'b0;
    mptr = (k + 1) % int'(N);
    #1 drive_reqs();
    #1;
    check("conv_busy", 32'(busy), 32'd1);
    check("conv_out_valid", 32'(out_valid), 32'd0);
    check("conv_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_id", 32'(out_id), 32'(k));
    check("out_gray", 32'(out_gray), 32'(g));
    check("out_bin", 32'(out_bin), 32'(ref_bin(g)));
    check("out_req_ready", 32'(req_ready), 32'd0);
    check("out_count", 32'(conv_count), 32'(exp_count));
    bin_o = out_bin;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_bin", 32'(out_bin), 32'(ref_bin(g)));
      check("stall_id", 32'(out_id), 32'(k));
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_count", 32'(conv_count), 32'(exp_count));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("oready_no_grant", 32'(req_ready), 32'd0);
    @(posedge clk);
    exp_count = exp_count + 16'd1;
    #1;
    check("accept_count", 32'(conv_count), 32'(exp_count));
    check("accept_out_valid", 32'(out_valid), 32'd0);
    check("accept_busy", 32'(busy), 32'd0);
  endtask

  // Grant one request, then reset while in CONV (depth 1) or OUT (depth 2).
  task automatic abort_txn(input int depth);
    int k;
    @(negedge clk);
    out_ready = 1'b0;
    drive_reqs();
    #1;
    k = pick();
    check("abort_grant", 32'(req_ready), (k < 0) ? 32'd0 : (32'd1 << k));
    @(posedge clk);
    if (k >= 0) pend[k] = 1'b0;
    #1 drive_reqs();
    for (int c = 1; c < depth; c++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    mptr = 0;
    exp_count = 16'h0000;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(conv_count), 32'd0);
    check("abort_out_id", 32'(out_id), 32'd0);
    check("abort_out_bin", 32'(out_bin), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check("abort_no_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int           k;
    logic [W-1:0] ob;
    logic [W-1:0] spot_g [4];
    logic [W-1:0] spot_b [4];
    spot_g = '{4'b0110, 4'b1011, 4'b1111, 4'b0011};
    spot_b = '{4'b0100, 4'b1101, 4'b1010, 4'b0010};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    req_valid = '0;
    req_gray  = '0;
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 1'b0;
      word[i] = '0;
    end
    mptr = 0;
    exp_count = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_count", 32'(conv_count), 32'd0);
    check("rst_out_bin", 32'(out_bin), 32'd0);
    check("rst_out_gray", 32'(out_gray), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    rst_n = 1'b1;

    // Single conversion on requester 2
    pend[2] = 1'b1;
    word[2] = 4'b1000;
    run_txn(0, k, ob);
    check("single_id", 32'(k), 32'd2);
    check("single_bin", 32'(ob), 32'h0000000F);
    check("single_count", 32'(conv_count), 32'd1);

    // All codes through requester 0
    for (int c = 0; c < (1 << W); c++) begin
      pend[0] = 1'b1;
      word[0] = W'(c);
      run_txn(0, k, ob);
    end
    for (int j = 0; j < 4; j++) begin
      pend[0] = 1'b1;
      word[0] = spot_g[j];
      run_txn(0, k, ob);
      check("spot_bin", 32'(ob), 32'(spot_b[j]));
    end

    // Round-robin with every requester continuously valid
    reset_pulse();
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 1'b1;
      word[i] = W'(3 * i + 1);
    end
    for (int t = 0; t < 6; t++) begin
      run_txn(0, k, ob);
      check("rr_order", 32'(k), 32'(t % int'(N)));
      if (k >= 0) begin
        pend[k] = 1'b1;
        word[k] = W'(5 * t + k + 2);
      end
    end

    // Backpressure: five stalled cycles in OUT
    reset_pulse();
    pend[1] = 1'b1;
    word[1] = 4'b1101;
    pend[3] = 1'b1;
    word[3] = 4'b0101;
    run_txn(5, k, ob);
    run_txn(2, k, ob);

    // Reset during CONV, then ptr must restart at 0
    clear_pend();
    pend[1] = 1'b1;
    word[1] = 4'b0111;
    abort_txn(1);
    pend[3] = 1'b1;
    word[3] = 4'b1010;
    run_txn(0, k, ob);
    check("post_reset_id3", 32'(k), 32'd3);

    // Reset during OUT after ptr has advanced to 3
    pend[2] = 1'b1;
    word[2] = 4'b0100;
    abort_txn(2);
    pend[1] = 1'b1;
    word[1] = 4'b1110;
    pend[3] = 1'b1;
    word[3] = 4'b0001;
    run_txn(0, k, ob);
    check("post_out_reset_id", 32'(k), 32'd1);
    run_txn(1, k, ob);

    // Counter rollover
    @(negedge clk);
    force dut.conv_count_q = 16'hFFFF;
    #1 release dut.conv_count_q;
    exp_count = 16'hFFFF;
    pend[0] = 1'b1;
    word[0] = 4'b1001;
    run_txn(0, k, ob);
    check("wrap_count", 32'(conv_count), 32'd0);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          word[i] = W'($urandom);
        end
      end
      if (pick() < 0) idle_cycle();
      else run_txn(int'($urandom_range(0, 3)), k, ob);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_gray_conv_arbiter
